// File: rtl/ex_div_seq.sv
// ----------------------------------------------------------------------------
// ex_div_seq
//   Multi-cycle DIV/DIVU sequencer for the EX stage. Operands are captured on
//   start, a 32-step restoring division produces one quotient bit per cycle,
//   and the signed result is loaded into registered quotient/remainder outputs
//   that feed the HI/LO write path.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   start      EX holds a DIV/DIVU instruction (sampled only in IDLE)
//   signed_op  1 = DIV (two's complement), 0 = DIVU (sampled with start)
//   dividend   numerator (sampled with start)
//   divisor    denominator (sampled with start)
//   cancel     pipeline flush, aborts any operation in progress
//   stall_req  combinational pipeline freeze request
//   ready      registered one-cycle result-valid pulse
//   quotient   registered quotient (LO)
//   remainder  registered remainder (HI)
//   dbg_state  current FSM state (0 = IDLE, 1 = BUSY, 2 = DONE)
//
// Handshake: start is a level request, not a valid/ready transfer. The
// operation is accepted on the first rising edge where the FSM is IDLE,
// start=1 and cancel=0. The requester keeps the instruction in EX while
// stall_req=1; ready=1 marks the single cycle in which quotient/remainder
// carry the new result, and stall_req is 0 in that cycle so EX advances.
// ----------------------------------------------------------------------------
module ex_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall_req,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] dvd_q,       dvd_d;      // dividend magnitude, shifted out MSB-first
  logic [WIDTH-1:0] dvs_q,       dvs_d;      // divisor magnitude
  logic [WIDTH-1:0] quo_q,       quo_d;      // quotient bits collected LSB-first
  logic [WIDTH:0]   prem_q,      prem_d;     // partial remainder
  logic             sign_q_q,    sign_q_d;   // negate quotient at the end
  logic             sign_r_q,    sign_r_d;   // negate remainder at the end
  logic             ready_q,     ready_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  // One restoring step. The shifted value is two bits wider than the operands
  // so the sign of the trial subtraction is always its MSB.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH:0]   prem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  always_comb begin
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    trial    = shifted - {2'b00, dvs_q};
    qbit     = ~trial[WIDTH+1];
    prem_nxt = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
    quo_nxt  = {quo_q[WIDTH-2:0], qbit};
  end

  // Magnitudes are only taken for signed operations; DIVU uses raw operands.
  always_comb begin
    dvd_abs = (signed_op && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
    dvs_abs = (signed_op && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    prem_d      = prem_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    ready_d     = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (cancel) begin
      // Flush wins over everything; the last result stays on the outputs.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Divide by zero completes immediately with a zero result.
              state_d     = S_DONE;
              ready_d     = 1'b1;
              quotient_d  = '0;
              remainder_d = '0;
            end else begin
              state_d  = S_BUSY;
              cnt_d    = '0;
              dvd_d    = dvd_abs;
              dvs_d    = dvs_abs;
              quo_d    = '0;
              prem_d   = '0;
              sign_q_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              sign_r_d = signed_op & dividend[WIDTH-1];
            end
          end
        end

        S_BUSY: begin
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
          quo_d  = quo_nxt;
          prem_d = prem_nxt;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d     = S_DONE;
            ready_d     = 1'b1;
            quotient_d  = sign_q_q ? (WIDTH'(0) - quo_nxt) : quo_nxt;
            remainder_d = sign_r_q ? (WIDTH'(0) - prem_nxt[WIDTH-1:0])
                                   : prem_nxt[WIDTH-1:0];
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      prem_q      <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      prem_q      <= prem_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      ready_q     <= ready_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Freeze the pipeline while a request is pending or in flight; the gating
  // by rst keeps it low during reset even if start is asserted.
  assign stall_req = rst & ~cancel &
                     (((state_q == S_IDLE) & start) | (state_q == S_BUSY));
  assign ready     = ready_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// ----------------------------------------------------------------------------
// tb_ex_div_seq
//   Directed and randomized bench for ex_div_seq. The reference result comes
//   from plain 64-bit integer division; outputs are checked every cycle.
// ----------------------------------------------------------------------------
module tb_ex_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall_req;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected {quotient, remainder} for each operation expected to complete.
  logic [63:0] exp_q[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  ex_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .stall_req (stall_req),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=0x%08h exp=0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference: MIPS DIV/DIVU semantics via wide integer arithmetic
  // (truncating division, remainder takes dividend sign, x/0 -> 0,0).
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint la, lb, lq, lr;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    lq = la / lb;
    lr = la % lb;
    return {lq[31:0], lr[31:0]};
  endfunction

  // ---------------- compare process ----------------
  // Each cycle: a ready pulse must match the oldest expected result; otherwise
  // the outputs must still hold the last delivered result.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      last_q = '0;
      last_r = '0;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
    end else if (ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {31'd0, ready}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", quotient, e[63:32]);
        chk("remainder", remainder, e[31:0]);
        last_q = e[63:32];
        last_r = e[31:0];
      end
    end else begin
      chk("hold_quotient", quotient, last_q);
      chk("hold_remainder", remainder, last_r);
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one divide and wait for its ready pulse, checking latency and the
  // number of stall cycles seen while waiting.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n_stall;
    int cyc;
    bit seen;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    exp_q.push_back(model(sgn, a, b));
    @(negedge clk);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    n_stall   = 0;
    cyc       = 0;
    seen      = 0;
    #1;
    if (stall_req) n_stall++;
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        seen = 1;
        chk("stall_at_ready", {31'd0, stall_req}, 32'd0);
      end else if (stall_req) begin
        n_stall++;
      end
    end
    chk("ready_seen", {31'd0, seen}, 32'd1);
    chk("latency", cyc, exp_lat);
    chk("stall_cycles", n_stall, exp_lat);
  endtask

  task automatic issue_only(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    start     = 1'b1;   // stall_req must stay low during reset regardless
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    cancel    = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_state_idle", {30'd0, dbg_state}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with literal expectations.
    run_div(1'b0, 32'd100, 32'd7);
    chk("divu_100_7_q", quotient, 32'd14);
    chk("divu_100_7_r", remainder, 32'd2);

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_q", quotient, 32'hFFFF_FFFD);
    chk("div_m7_2_r", remainder, 32'hFFFF_FFFF);

    run_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    chk("div_7_m2_q", quotient, 32'hFFFF_FFFD);
    chk("div_7_m2_r", remainder, 32'd1);

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_q", quotient, 32'h8000_0000);
    chk("div_ovf_r", remainder, 32'd0);

    run_div(1'b0, 32'd5, 32'd0);
    chk("div0_q", quotient, 32'd0);
    chk("div0_r", remainder, 32'd0);

    // Non-zero result held, then a cancelled operation must not disturb it.
    run_div(1'b0, 32'd50, 32'd8);
    issue_only(32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    chk("cancel_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_state_idle", {30'd0, dbg_state}, 32'd0);
    chk("cancel_stall_after", {31'd0, stall_req}, 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_keep_q", quotient, 32'd6);
    chk("cancel_keep_r", remainder, 32'd2);

    // Back-to-back divides.
    run_div(1'b0, 32'd9, 32'd3);
    chk("b2b_1_q", quotient, 32'd3);
    chk("b2b_1_r", remainder, 32'd0);
    run_div(1'b0, 32'd10, 32'd4);
    chk("b2b_2_q", quotient, 32'd2);
    chk("b2b_2_r", remainder, 32'd2);

    // Asynchronous reset in the middle of BUSY, between clock edges.
    issue_only(32'd12345, 32'd67);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("areset_ready", {31'd0, ready}, 32'd0);
    chk("areset_quotient", quotient, 32'd0);
    chk("areset_remainder", remainder, 32'd0);
    chk("areset_stall", {31'd0, stall_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      int          mode;
      sgn  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      a    = $urandom();
      if (mode == 0)      b = 32'd0;
      else if (mode < 4)  b = $urandom_range(1, 20);
      else if (mode < 6)  b = 32'hFFFF_FFFF - $urandom_range(0, 20);
      else                b = $urandom();
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      run_div(sgn, a, b);
    end

    repeat (3) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
